// File: rtl/mp_rw_mem_pkg.sv
// Shared types for the multi-port byte-lane memory: FSM states and lane-count helper.
package mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int calc_lanes(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

endpackage

// File: rtl/mp_rw_mem_if.sv
// Request/response bundle of mp_rw_mem; every per-port field is flattened, port p at slice p.
interface mp_rw_mem_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 8,
  parameter int NUM_PORTS  = 2
);

  localparam int LANES = calc_lanes(DATA_WIDTH, LANE_WIDTH);

  logic [NUM_PORTS-1:0]            re;
  logic [NUM_PORTS-1:0]            we;
  logic [NUM_PORTS*LANES-1:0]      be;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wd;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rd;
  logic [NUM_PORTS-1:0]            rd_valid;
  logic                            init_busy;

  modport master (
    output re, we, be, addr, wd,
    input  rd, rd_valid, init_busy
  );

  modport slave (
    input  re, we, be, addr, wd,
    output rd, rd_valid, init_busy
  );

endinterface

// File: rtl/mp_rw_mem_rd_pipe.sv
// Extra read-return stages (data + valid) appended after the first read register.
module mem_rd_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_s;
    assign unused_s = clk ^ rst_n;
    assign data_o   = data_i;
    assign valid_o  = valid_i;
  end else begin : g_stages
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    // Unconditional shift: holding behaviour comes from the upstream register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
        valid_q <= '0;
      end else begin
        data_q[0]  <= data_i;
        valid_q[0] <= valid_i;
        for (int i = 1; i < DEPTH; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/mp_rw_mem.sv
// Multi-port lane-enabled RAM with a zeroing sequence after reset and
// configurable read latency and read/write collision policy.
module mp_rw_mem
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int LANE_WIDTH  = 8,
  parameter int NUM_PORTS   = 2,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0
) (
  input logic        clk,
  input logic        rst_n,
  mp_rw_mem_if.slave mem_if
);

  localparam int LANES = calc_lanes(DATA_WIDTH, LANE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("mp_rw_mem: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
    $error("mp_rw_mem: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_bad_ports
    $error("mp_rw_mem: NUM_PORTS must be 1..4");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q;
  logic                    ready_s;
  logic [DATA_WIDTH-1:0]   mem_q     [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_s    [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   merged_s  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   rd_q      [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   rd_d      [NUM_PORTS];
  logic [NUM_PORTS-1:0]    rv_q, rv_d;
  logic [DATA_WIDTH-1:0]   pipe_rd_s [NUM_PORTS];
  logic                    pipe_rv_s [NUM_PORTS];

  // Clear sequence walks every word once, then parks in READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = READY;
        end else begin
          state_d = INIT;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, clear counter and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == INIT);
    end
  end

  assign ready_s = (state_q == READY);

  // Unpack per-port addresses
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_s[p] = mem_if.addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Word at each port's address after all same-cycle writes; later ports override per lane
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      merged_s[p] = mem_q[addr_s[p]];
      for (int q = 0; q < NUM_PORTS; q++) begin
        for (int l = 0; l < LANES; l++) begin
          merged_s[p][l*LANE_WIDTH +: LANE_WIDTH] =
            (mem_if.we[q] && (addr_s[q] == addr_s[p]) && mem_if.be[q*LANES + l])
              ? mem_if.wd[q*DATA_WIDTH + l*LANE_WIDTH +: LANE_WIDTH]
              : merged_s[p][l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // First read stage: capture on an accepted read, otherwise hold
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rv_d[p] = mem_if.re[p] && ready_s;
      if (rv_d[p]) begin
        rd_d[p] = (WRITE_FIRST != 0) ? merged_s[p] : mem_q[addr_s[p]];
      end else begin
        rd_d[p] = rd_q[p];
      end
    end
  end

  // First read stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_q[p] <= '0;
      end
      rv_q <= '0;
    end else begin
      rd_q <= rd_d;
      rv_q <= rv_d;
    end
  end

  // Storage array has no reset; zeroing happens only through the clear sequence
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (mem_if.we[p]) begin
          mem_q[addr_s[p]] <= merged_s[p];
        end
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RD_LATENCY - 1)
    ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (rd_q[gp]),
      .valid_i (rv_q[gp]),
      .data_o  (pipe_rd_s[gp]),
      .valid_o (pipe_rv_s[gp])
    );
  end

  // Repack per-port read returns onto the bus
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      mem_if.rd[p*DATA_WIDTH +: DATA_WIDTH] = pipe_rd_s[p];
      mem_if.rd_valid[p]                    = pipe_rv_s[p];
    end
  end

  assign mem_if.init_busy = busy_q;

endmodule

// File: doc/mp_rw_mem.md
MP_RW_MEM -- requirements
Module: mp_rw_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: address bits; depth SHALL be 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8: word width; SHALL be a multiple of LANE_WIDTH.
REQ-003 Parameter LANE_WIDTH, default 8: byte-enable granularity; LANES = DATA_WIDTH/LANE_WIDTH.
REQ-004 Parameter NUM_PORTS, default 2: independent read/write ports, range 1..4.
REQ-005 Parameter RD_LATENCY, default 1: read latency in cycles, legal values 1 or 2.
REQ-006 Parameter WRITE_FIRST, default 0: 0 = read-first, 1 = write-first on read/write collision.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 re  in  NUM_PORTS  per-port read enable.
REQ-010 we  in  NUM_PORTS  per-port write enable.
REQ-011 be  in  NUM_PORTS*LANES  per-port lane enables; port p uses bits [p*LANES +: LANES].
REQ-012 addr  in  NUM_PORTS*ADDR_WIDTH  flattened per-port address.
REQ-013 wd  in  NUM_PORTS*DATA_WIDTH  flattened per-port write data.
REQ-014 rd  out  NUM_PORTS*DATA_WIDTH  flattened per-port read data.
REQ-015 rd_valid  out  NUM_PORTS  per-port read-data-valid strobe.
REQ-016 init_busy  out  1  high while the clear sequence runs; requests ignored.

Function
REQ-017 FSM states SHALL be INIT and READY; INIT is entered on reset.
REQ-018 INIT: an internal counter SHALL write all-zero to word 0..2**ADDR_WIDTH-1, one word per cycle, then move to READY; duration exactly 2**ADDR_WIDTH cycles after rst_n deasserts.
REQ-019 init_busy SHALL be 1 in INIT, 0 in READY; re/we SHALL be ignored in INIT (no write, no rd_valid).
REQ-020 READY write: for port p with we[p]=1, each lane l with be[p*LANES+l]=1 SHALL be updated with the matching wd lane at the clock edge; lanes with be=0 unchanged.
REQ-021 Write-write collision (same address, same cycle): per lane, the highest-indexed enabling port SHALL win.
REQ-022 READY read: re[p]=1 SHALL produce rd lane data for addr[p] and rd_valid[p]=1 exactly RD_LATENCY cycles later.
REQ-023 WRITE_FIRST=0: a read returns the word content before any write in the same cycle (any port).
REQ-024 WRITE_FIRST=1: a read returns the word content after all same-cycle writes of all ports (REQ-021 merge applied).
REQ-025 rd[p] SHALL hold its last value when no read completes; rd_valid[p] SHALL be a one-cycle pulse per read.
REQ-026 Reads and writes on different ports to different addresses SHALL be fully independent, one operation per port per cycle, no stalls.
REQ-027 With RD_LATENCY=2 the second stage SHALL be a register on data and valid, no extra gating.
REQ-028 Address wrap: counter in INIT wraps to 0 only on reset; addr is always in range by width.

Reset
REQ-029 While rst_n=0: rd=0, rd_valid=0, init_busy=1, FSM=INIT, clear counter=0, all pipeline valids cleared.
REQ-030 Reset asserted mid-INIT or mid-READY SHALL abort in-flight reads (no rd_valid) and restart the full clear sequence.
REQ-031 Memory array SHALL not be reset directly; its zeroing occurs only through INIT.

Structure
REQ-032 Shared package mem_pkg SHALL hold the FSM state typedef (INIT, READY) and a LANES-computation function.
REQ-033 One sub-module mem_rd_pipe (per-port data+valid pipeline, depth RD_LATENCY-1, async active-low reset) SHALL be instantiated NUM_PORTS times.
REQ-034 Illegal parameters (RD_LATENCY not 1/2, DATA_WIDTH not multiple of LANE_WIDTH) SHALL trigger an elaboration-time error.

Verification
REQ-035 Reset release, defaults -> init_busy high for exactly 64 cycles; then re[0] at addr 0x3F -> rd[0]=0x00, rd_valid[0] pulse after 1 cycle.
REQ-036 Port 0 writes 0xA5 addr 0x10, next cycle port 1 reads 0x10 -> port 1 rd=0xA5 after RD_LATENCY.
REQ-037 DATA_WIDTH=16: word 0x1234 at addr 5, write 0xABCD with be=2'b10 -> read returns 0xAB34.
REQ-038 Same cycle: port 0 writes 0x11, port 1 writes 0x22 to addr 7, port 0 reads 7 -> WRITE_FIRST=0 returns old value, WRITE_FIRST=1 returns 0x22; later read returns 0x22.
REQ-039 rst_n pulsed low at INIT count 20 -> init_busy stays high 64 further cycles after release; rst_n low with read in flight -> no rd_valid.
REQ-040 RD_LATENCY=2, back-to-back reads on both ports, addresses 0..15 pre-written -> rd_valid every cycle, data matches address order two cycles later.
